// File: rtl/dht11_disp_sched_pkg.sv
// Shared definitions for the DHT11 read/display scheduler.
//   state_t     : read-pacing FSM states
//   POINT_1DEC  : decimal-point mask for a one-decimal "xx.y" value
//   DECI_MAX    : largest decimal digit shown
//   fmt_value() : int/deci byte pair -> binary display value int*10 + digit
package dht11_disp_sched_pkg;

  typedef enum logic [1:0] {
    ST_PWRUP = 2'd0,
    ST_REQ   = 2'd1,
    ST_WAIT  = 2'd2,
    ST_HOLD  = 2'd3
  } state_t;

  localparam logic [5:0] POINT_1DEC = 6'b000010;
  localparam logic [6:0] DECI_MAX   = 7'd9;

  // bit7 of the decimal byte carries the sign, so only [6:0] is the digit;
  // anything above 9 is not a single digit and is clamped.
  function automatic logic [19:0] fmt_value(input logic [7:0] int_b, input logic [7:0] deci_b);
    logic [6:0] d;
    if (deci_b[6:0] > DECI_MAX) begin
      d = DECI_MAX;
    end else begin
      d = deci_b[6:0];
    end
    return ({12'd0, int_b} * 20'd10) + {13'd0, d};
  endfunction

endpackage

// File: rtl/dht11_disp_sched_if.sv
// Bundle between the scheduler, dht11_ctrl and seg_dynamic.
//   sensor side : dht11_busy, dht11_valid, temp/humi int/deci bytes (to scheduler),
//                 dht11_start (from scheduler)
//   display side: data, point, seg_en, sign, disp_sel, err_flag (from scheduler)
// master = surrounding logic (sensor controller + display), slave = scheduler.
interface dht11_disp_sched_if;

  logic        dht11_busy;
  logic        dht11_valid;
  logic [7:0]  temp_int;
  logic [7:0]  temp_deci;
  logic [7:0]  humi_int;
  logic [7:0]  humi_deci;
  logic        dht11_start;
  logic [19:0] data;
  logic [5:0]  point;
  logic        seg_en;
  logic        sign;
  logic        disp_sel;
  logic        err_flag;

  modport master (
    output dht11_busy, dht11_valid, temp_int, temp_deci, humi_int, humi_deci,
    input  dht11_start, data, point, seg_en, sign, disp_sel, err_flag
  );

  modport slave (
    input  dht11_busy, dht11_valid, temp_int, temp_deci, humi_int, humi_deci,
    output dht11_start, data, point, seg_en, sign, disp_sel, err_flag
  );

endinterface

// File: rtl/dht11_disp_sched_ms_tick_gen.sv
// Millisecond tick generator.
//   clk, rst_n : clock, async active-low reset
//   tick       : registered 1-cycle pulse every CNT_1MS cycles
module ms_tick_gen #(
  parameter int CNT_1MS = 50_000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam logic [31:0] CNT_LAST = 32'(CNT_1MS - 1);

  logic [31:0] cnt_r;
  logic        tick_r;

  // Free-running divider; tick fires on the wrap cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r  <= 32'd0;
      tick_r <= 1'b0;
    end else if (cnt_r == CNT_LAST) begin
      cnt_r  <= 32'd0;
      tick_r <= 1'b1;
    end else begin
      cnt_r  <= cnt_r + 32'd1;
      tick_r <= 1'b0;
    end
  end

  assign tick = tick_r;

endmodule

// File: rtl/dht11_disp_sched.sv
// Scheduler between dht11_ctrl and seg_dynamic: paces sensor reads, times out
// missing responses, latches good frames and alternates the display between
// temperature and humidity pages.
//   sys_clk, sys_rst_n : clock, async active-low reset
//   bus (slave)        : sensor handshake/bytes in, start request and display fields out
module dht11_disp_sched
  import dht11_disp_sched_pkg::*;
#(
  parameter int CNT_1MS        = 50_000,
  parameter int PWRUP_MS       = 1000,
  parameter int READ_PERIOD_MS = 2000,
  parameter int RESP_TMO_MS    = 100,
  parameter int DISP_PERIOD_MS = 3000,
  parameter int STALE_READS    = 3
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  dht11_disp_sched_if.slave bus
);

  localparam logic [31:0] PWRUP_LAST = 32'(PWRUP_MS - 1);
  localparam logic [31:0] PER_LAST   = 32'(READ_PERIOD_MS - 1);
  localparam logic [31:0] TMO_LAST   = 32'(RESP_TMO_MS - 1);
  localparam logic [31:0] DISP_LAST  = 32'(DISP_PERIOD_MS - 1);
  localparam logic [31:0] STALE      = 32'(STALE_READS);

  logic        tick_s;
  state_t      state_r, state_nxt_s;
  logic        start_req_s, latch_s, timeout_s;
  logic [31:0] pwr_cnt_r, per_cnt_r, tmo_cnt_r, disp_cnt_r, miss_r, miss_inc_s;
  logic        have_r, err_r, disp_sel_r, start_r, seg_en_r, sign_r;
  logic [7:0]  lat_ti_r, lat_td_r, lat_hi_r, lat_hd_r;
  logic [19:0] data_r;
  logic [5:0]  point_r;

  ms_tick_gen #(.CNT_1MS(CNT_1MS)) u_tick (
    .clk   (sys_clk),
    .rst_n (sys_rst_n),
    .tick  (tick_s)
  );

  // Read FSM state register.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_r <= ST_PWRUP;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Read FSM next-state logic; a valid frame beats a timeout on the same tick.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_PWRUP: if (tick_s && (pwr_cnt_r == PWRUP_LAST)) state_nxt_s = ST_REQ;
                else state_nxt_s = ST_PWRUP;
      ST_REQ:   if (!bus.dht11_busy) state_nxt_s = ST_WAIT;
                else state_nxt_s = ST_REQ;
      ST_WAIT:  if (bus.dht11_valid) state_nxt_s = ST_HOLD;
                else if (tick_s && (tmo_cnt_r == TMO_LAST)) state_nxt_s = ST_HOLD;
                else state_nxt_s = ST_WAIT;
      ST_HOLD:  if (tick_s && (per_cnt_r == PER_LAST)) state_nxt_s = ST_REQ;
                else state_nxt_s = ST_HOLD;
      default:  state_nxt_s = ST_PWRUP;
    endcase
  end

  // Read FSM strobes driving the counters, status and start registers.
  always_comb begin
    start_req_s = 1'b0;
    latch_s     = 1'b0;
    timeout_s   = 1'b0;
    case (state_r)
      ST_REQ:  start_req_s = !bus.dht11_busy;
      ST_WAIT: begin
        latch_s   = bus.dht11_valid;
        timeout_s = !bus.dht11_valid && tick_s && (tmo_cnt_r == TMO_LAST);
      end
      default: begin
        start_req_s = 1'b0;
        latch_s     = 1'b0;
        timeout_s   = 1'b0;
      end
    endcase
  end

  // Power-up delay, request period and response timeout counters (ms units).
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      pwr_cnt_r <= 32'd0;
      per_cnt_r <= 32'd0;
      tmo_cnt_r <= 32'd0;
    end else begin
      if ((state_r == ST_PWRUP) && tick_s) pwr_cnt_r <= pwr_cnt_r + 32'd1;
      if (start_req_s) begin
        per_cnt_r <= 32'd0;
        tmo_cnt_r <= 32'd0;
      end else if (tick_s) begin
        if ((state_r == ST_WAIT) || (state_r == ST_HOLD)) per_cnt_r <= per_cnt_r + 32'd1;
        if (state_r == ST_WAIT) tmo_cnt_r <= tmo_cnt_r + 32'd1;
      end
    end
  end

  assign miss_inc_s = (miss_r >= STALE) ? STALE : (miss_r + 32'd1);

  // Frame latch and staleness tracking.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      lat_ti_r <= 8'd0;
      lat_td_r <= 8'd0;
      lat_hi_r <= 8'd0;
      lat_hd_r <= 8'd0;
      miss_r   <= 32'd0;
      err_r    <= 1'b0;
      have_r   <= 1'b0;
    end else if (latch_s) begin
      lat_ti_r <= bus.temp_int;
      lat_td_r <= bus.temp_deci;
      lat_hi_r <= bus.humi_int;
      lat_hd_r <= bus.humi_deci;
      miss_r   <= 32'd0;
      err_r    <= 1'b0;
      have_r   <= 1'b1;
    end else if (timeout_s) begin
      miss_r <= miss_inc_s;
      if (miss_inc_s == STALE) err_r <= 1'b1;
    end
  end

  // Page rotation, free-running from reset and independent of reads.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      disp_cnt_r <= 32'd0;
      disp_sel_r <= 1'b0;
    end else if (tick_s) begin
      if (disp_cnt_r == DISP_LAST) begin
        disp_cnt_r <= 32'd0;
        disp_sel_r <= ~disp_sel_r;
      end else begin
        disp_cnt_r <= disp_cnt_r + 32'd1;
      end
    end
  end

  // Registered outputs; display fields freeze while the display is disabled.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      start_r  <= 1'b0;
      seg_en_r <= 1'b0;
      data_r   <= 20'd0;
      point_r  <= 6'd0;
      sign_r   <= 1'b0;
    end else begin
      start_r  <= start_req_s;
      seg_en_r <= have_r & ~err_r;
      if (have_r && !err_r) begin
        data_r  <= disp_sel_r ? fmt_value(lat_hi_r, lat_hd_r) : fmt_value(lat_ti_r, lat_td_r);
        point_r <= POINT_1DEC;
        sign_r  <= ~disp_sel_r & lat_td_r[7];
      end
    end
  end

  assign bus.dht11_start = start_r;
  assign bus.data        = data_r;
  assign bus.point       = point_r;
  assign bus.seg_en      = seg_en_r;
  assign bus.sign        = sign_r;
  assign bus.disp_sel    = disp_sel_r;
  assign bus.err_flag    = err_r;

endmodule

// File: tb/tb_dht11_disp_sched.sv
// Self-checking bench for dht11_disp_sched with shortened timing.
// A time-based reference model predicts every output each cycle; table
// vectors and hand sequences add explicit checks on top.
module tb_dht11_disp_sched;

  localparam int CNT_1MS = 10, PWRUP_MS = 5, READ_PERIOD_MS = 20;
  localparam int RESP_TMO_MS = 4, DISP_PERIOD_MS = 30, STALE_READS = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  dht11_disp_sched_if bus();

  dht11_disp_sched #(
    .CNT_1MS(CNT_1MS), .PWRUP_MS(PWRUP_MS), .READ_PERIOD_MS(READ_PERIOD_MS),
    .RESP_TMO_MS(RESP_TMO_MS), .DISP_PERIOD_MS(DISP_PERIOD_MS), .STALE_READS(STALE_READS)
  ) dut (
    .sys_clk   (clk),
    .sys_rst_n (rst_n),
    .bus       (bus)
  );

  int tests = 0;
  int fails = 0;

  // reference model: edges counted from reset release, ms tick k lands on edge k*CNT_1MS+1
  int edge_n, req_at, last_start, tmo_at, m_miss, m_data, m_point;
  bit m_open, m_have, m_err, m_sel, m_start, m_seg, m_sign;
  logic [7:0] l_ti, l_td, l_hi, l_hd;

  typedef struct {
    logic [7:0] ti, td, hi, hd;
    int exp_t; bit exp_s; int exp_h;
  } vec_t;
  vec_t tbl [6];

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  function automatic int ref_fmt(input int i, input int d);
    int dd;
    dd = d % 128;
    if (dd > 9) dd = 9;
    return i * 10 + dd;
  endfunction

  task automatic model_reset();
    edge_n = 0; req_at = CNT_1MS * PWRUP_MS + 1; last_start = 0; tmo_at = 0;
    m_miss = 0; m_data = 0; m_point = 0;
    m_open = 0; m_have = 0; m_err = 0; m_sel = 0; m_start = 0; m_seg = 0; m_sign = 0;
    l_ti = 8'd0; l_td = 8'd0; l_hi = 8'd0; l_hd = 8'd0;
  endtask

  task automatic model_edge();
    int ft;
    m_start = 0;
    m_seg = m_have && !m_err;
    if (m_seg) begin
      m_data  = m_sel ? ref_fmt(l_hi, l_hd) : ref_fmt(l_ti, l_td);
      m_point = 2;
      m_sign  = !m_sel && l_td[7];
    end
    if (m_open) begin
      if (bus.dht11_valid) begin
        l_ti = bus.temp_int; l_td = bus.temp_deci; l_hi = bus.humi_int; l_hd = bus.humi_deci;
        m_miss = 0; m_err = 0; m_have = 1; m_open = 0;
      end else if (edge_n == tmo_at) begin
        if (m_miss < STALE_READS) m_miss++;
        if (m_miss == STALE_READS) m_err = 1;
        m_open = 0;
      end
    end
    if (edge_n > req_at && last_start < req_at && !bus.dht11_busy) begin
      m_start = 1;
      last_start = edge_n;
      ft = edge_n - ((edge_n - 1) % CNT_1MS) + CNT_1MS;
      tmo_at = ft + CNT_1MS * (RESP_TMO_MS - 1);
      req_at = ft + CNT_1MS * (READ_PERIOD_MS - 1);
      m_open = 1;
    end
    if (edge_n > 1 && ((edge_n - 1) % (CNT_1MS * DISP_PERIOD_MS)) == 0) m_sel = !m_sel;
  endtask

  task automatic check_all();
    chk("dht11_start", bus.dht11_start, m_start);
    chk("data", bus.data, m_data);
    chk("point", bus.point, m_point);
    chk("seg_en", bus.seg_en, m_seg);
    chk("sign", bus.sign, m_sign);
    chk("disp_sel", bus.disp_sel, m_sel);
    chk("err_flag", bus.err_flag, m_err);
  endtask

  task automatic cyc();
    @(posedge clk);
    edge_n++;
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  task automatic pulse_valid(input logic [7:0] ti, td, hi, hd);
    bus.temp_int = ti; bus.temp_deci = td; bus.humi_int = hi; bus.humi_deci = hd;
    bus.dht11_valid = 1'b1;
    cyc();
    bus.dht11_valid = 1'b0;
  endtask

  task automatic wait_start();
    bit ok;
    ok = 0;
    for (int i = 0; i < 600 && !ok; i++) begin
      cyc();
      if (m_start) ok = 1;
    end
    if (!ok) chk("wait_start_timeout", 0, 1);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_start"}, bus.dht11_start, 0);
    chk({tag, "_data"}, bus.data, 0);
    chk({tag, "_point"}, bus.point, 0);
    chk({tag, "_seg_en"}, bus.seg_en, 0);
    chk({tag, "_sign"}, bus.sign, 0);
    chk({tag, "_disp_sel"}, bus.disp_sel, 0);
    chk({tag, "_err"}, bus.err_flag, 0);
  endtask

  initial begin
    int first_s, second_s, nstart, bound;
    bit sel_b;
    tbl[0] = '{8'd25, 8'd3,    8'd60,  8'd0,   253,  1'b0, 600};
    tbl[1] = '{8'd2,  8'h85,   8'd40,  8'd2,   25,   1'b1, 402};
    tbl[2] = '{8'd30, 8'd12,   8'd55,  8'd99,  309,  1'b0, 559};
    tbl[3] = '{8'd255, 8'd9,   8'd255, 8'd127, 2559, 1'b0, 2559};
    tbl[4] = '{8'd0,  8'h80,   8'd0,   8'd0,   0,    1'b1, 0};
    tbl[5] = '{8'd18, 8'hFF,   8'd70,  8'd5,   189,  1'b1, 705};

    bus.dht11_busy = 1'b0; bus.dht11_valid = 1'b0;
    bus.temp_int = 8'd0; bus.temp_deci = 8'd0; bus.humi_int = 8'd0; bus.humi_deci = 8'd0;
    model_reset();
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;

    // first request after power-up delay, then one every read period
    first_s = -1; second_s = -1; nstart = 0;
    for (int i = 0; i < 260; i++) begin
      cyc();
      if (bus.dht11_start) begin
        nstart++;
        if (first_s < 0) first_s = edge_n;
        else if (second_s < 0) second_s = edge_n;
      end
    end
    chk("first_start_edge", first_s, 52);
    chk("second_start_edge", second_s, 252);
    chk("start_pulse_cycles", nstart, 2);

    // formatting table: both pages for each frame
    foreach (tbl[v]) begin
      wait_start();
      pulse_valid(tbl[v].ti, tbl[v].td, tbl[v].hi, tbl[v].hd);
      sel_b = m_sel;
      cyc();
      chk("tbl_data", bus.data, sel_b ? tbl[v].exp_h : tbl[v].exp_t);
      chk("tbl_sign", bus.sign, sel_b ? 0 : int'(tbl[v].exp_s));
      chk("tbl_seg_en", bus.seg_en, 1);
      chk("tbl_point", bus.point, 2);
      bound = 0;
      while (m_sel == sel_b && bound < 400) begin cyc(); bound++; end
      if (bound >= 400) chk("page_toggle_timeout", 0, 1);
      cyc();
      chk("tbl_data_page2", bus.data, sel_b ? tbl[v].exp_t : tbl[v].exp_h);
      chk("tbl_sign_page2", bus.sign, sel_b ? int'(tbl[v].exp_s) : 0);
    end

    // valid outside WAIT is ignored
    bound = 0;
    while (m_open && bound < 100) begin cyc(); bound++; end
    pulse_valid(8'd99, 8'd9, 8'd99, 8'd9);
    sel_b = m_sel;
    cyc();
    chk("hold_valid_ignored", bus.data, sel_b ? tbl[5].exp_h : tbl[5].exp_t);

    // busy across the request point delays the pulse, then exactly one
    bound = 0;
    while (!(edge_n >= req_at && last_start < req_at) && bound < 400) begin cyc(); bound++; end
    if (bound >= 400) chk("req_wait_timeout", 0, 1);
    bus.dht11_busy = 1'b1;
    nstart = 0;
    repeat (15) begin cyc(); if (bus.dht11_start) nstart++; end
    chk("busy_no_start", nstart, 0);
    bus.dht11_busy = 1'b0;
    nstart = 0;
    repeat (5) begin cyc(); if (bus.dht11_start) nstart++; end
    chk("busy_release_one_start", nstart, 1);

    // staleness: err after 3rd consecutive timeout, cleared by a good frame
    wait_start();
    pulse_valid(8'd25, 8'd3, 8'd60, 8'd0);
    bound = 0;
    while (m_miss != 2 && bound < 1000) begin cyc(); bound++; end
    chk("err_after_2_miss", bus.err_flag, 0);
    bound = 0;
    while (m_miss != 3 && bound < 1000) begin cyc(); bound++; end
    chk("err_after_3_miss", bus.err_flag, 1);
    cyc();
    chk("seg_en_off_on_err", bus.seg_en, 0);
    wait_start();
    pulse_valid(8'd30, 8'd5, 8'd45, 8'd1);
    chk("err_cleared", bus.err_flag, 0);
    sel_b = m_sel;
    cyc();
    chk("seg_en_back", bus.seg_en, 1);
    chk("recover_data", bus.data, sel_b ? 451 : 305);

    // reset mid-WAIT clears everything at once; restart after power-up delay
    wait_start();
    cyc();
    rst_n = 1'b0;
    #1;
    check_zero("midwait_reset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    first_s = -1;
    for (int i = 0; i < 60; i++) begin
      cyc();
      if (bus.dht11_start && first_s < 0) first_s = edge_n;
    end
    chk("start_after_reset", first_s, 52);

    // randomized traffic checked cycle by cycle against the model
    for (int p = 0; p < 3; p++) begin
      for (int i = 0; i < 4000; i++) begin
        bus.dht11_busy  = ($urandom_range(0, 99) < 20);
        bus.dht11_valid = ($urandom_range(0, 99) < ((p == 1) ? 0 : 6));
        bus.temp_int  = 8'($urandom_range(0, 255));
        bus.temp_deci = 8'($urandom_range(0, 255));
        bus.humi_int  = 8'($urandom_range(0, 255));
        bus.humi_deci = 8'($urandom_range(0, 255));
        cyc();
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
